rc4_ctrl: RTL and testbench

RC4_CTRL -- requirements
Module: rc4_ctrl

---
 rtl/rc4_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_rc4_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_ctrl.sv
`timescale 1ns/1ps
// rc4_ctrl -- session controller sitting between a host and an RC4 key
// generator. Holds a 16-byte key store, sequences the generator through
// S-box init (SINIT), key scheduling (KSA), optional keystream drop (DROP)
// and en/decryption (CRYPT), and XORs host data with the keystream.
//
// Build option: define RC4_DROP_EN to insert the DROP state, which
// discards the first 256 keystream bytes before CRYPT.
//
// Ports:
//   clk, rst                  clock, async active-low reset
//   key_wr/key_addr/key_wdata key store write port (IDLE only)
//   key_len                   key length, 0 or >16 means 16; sampled on start
//   start, stop               session begin pulse / abort-or-end
//   ks_byte, ks_valid         keystream from the key generator
//   din/din_valid/din_ready   input data handshake
//   dout/dout_valid/dout_ready output data handshake
//   NS                        generator mode (INIT/KEY_GENE/EN_DE_CODE)
//   key_init                  key byte fed to the generator during KSA
//   busy                      high whenever a session is active
module rc4_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_wr,
    input  logic [3:0] key_addr,
    input  logic [7:0] key_wdata,
    input  logic [4:0] key_len,
    input  logic       start,
    input  logic       stop,
    input  logic [7:0] ks_byte,
    input  logic       ks_valid,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic [7:0] dout,
    output logic       dout_valid,
    input  logic       dout_ready,
    output logic [1:0] NS,
    output logic [7:0] key_init,
    output logic       busy
);

    localparam int unsigned CNT_W  = 9;
    localparam int unsigned KIDX_W = 4;
    localparam int unsigned KEY_N  = 16;
    localparam logic [1:0]  NS_INIT     = 2'b00;
    localparam logic [1:0]  NS_KEY_GENE = 2'b01;
    localparam logic [1:0]  NS_CODE     = 2'b10;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(255);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SINIT = 3'd1,
        S_KSA   = 3'd2,
`ifdef RC4_DROP_EN
        S_DROP  = 3'd3,
`endif
        S_CRYPT = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [KIDX_W-1:0] kidx_q, kidx_d;
    logic [KIDX_W-1:0] klast_q;
    logic [7:0]        key_q [KEY_N];
    logic [7:0]        dout_q;
    logic              dout_valid_q;
    logic              sess_go;
    logic [KIDX_W-1:0] klast_new;

    // A start that coincides with stop is treated as stop.
    assign sess_go   = (state_q == S_IDLE) && start && !stop;
    // Last key index for the sampled length; 0 or >16 selects all 16 bytes.
    assign klast_new = ((key_len == 5'd0) || (key_len > 5'd16)) ?
                       KIDX_W'(KEY_N - 1) : KIDX_W'(key_len - 5'd1);

    // State register with sequencing counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            kidx_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            kidx_q  <= kidx_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        kidx_d  = kidx_q;
        case (state_q)
            S_IDLE: begin
                if (sess_go) begin
                    state_d = S_SINIT;
                    cnt_d   = '0;
                end
            end
            S_SINIT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_KSA;
                    cnt_d   = '0;
                    kidx_d  = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_KSA: begin
                kidx_d = (kidx_q == klast_q) ? '0 : kidx_q + KIDX_W'(1);
                if (cnt_q == CNT_LAST) begin
`ifdef RC4_DROP_EN
                    state_d = S_DROP;
`else
                    state_d = S_CRYPT;
`endif
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef RC4_DROP_EN
            // Only cycles carrying a keystream byte count as dropped.
            S_DROP: begin
                if (ks_valid) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_CRYPT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
`endif
            S_CRYPT: begin
                state_d = S_CRYPT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if ((state_q != S_IDLE) && stop) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            kidx_d  = '0;
        end
    end

    // Output decode.
    always_comb begin
        NS        = NS_INIT;
        busy      = 1'b1;
        key_init  = 8'h00;
        din_ready = 1'b0;
        case (state_q)
            S_IDLE:  busy = 1'b0;
            S_SINIT: NS = NS_INIT;
            S_KSA: begin
                NS       = NS_KEY_GENE;
                key_init = key_q[kidx_q];
            end
`ifdef RC4_DROP_EN
            S_DROP:  NS = NS_CODE;
`endif
            S_CRYPT: begin
                NS        = NS_CODE;
                din_ready = ks_valid & (~dout_valid_q | dout_ready);
            end
            default: busy = 1'b0;
        endcase
    end

    // Key store, sampled key length and output data register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < KEY_N; i++) key_q[i] <= 8'h00;
            klast_q      <= '0;
            dout_q       <= 8'h00;
            dout_valid_q <= 1'b0;
        end else begin
            if (state_q == S_IDLE) begin
                if (key_wr) key_q[key_addr] <= key_wdata;
                if (sess_go) klast_q <= klast_new;
            end
            // A stop throws away any output not yet taken.
            if (busy && stop) begin
                dout_q       <= 8'h00;
                dout_valid_q <= 1'b0;
            end else if (din_valid && din_ready) begin
                dout_q       <= din ^ ks_byte;
                dout_valid_q <= 1'b1;
            end else if (dout_ready) begin
                dout_valid_q <= 1'b0;
            end
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_rc4_ctrl.sv
`timescale 1ns/1ps
// Randomized self-checking bench for rc4_ctrl. Expected values come from
// a cycle-indexed view of a session (mode by elapsed cycles, key byte by
// modular index) and a small handshake scoreboard for the data path.
module tb_rc4_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_wr;
    logic [3:0] key_addr;
    logic [7:0] key_wdata;
    logic [4:0] key_len;
    logic       start, stop;
    logic [7:0] ks_byte;
    logic       ks_valid;
    logic [7:0] din;
    logic       din_valid, din_ready;
    logic [7:0] dout;
    logic       dout_valid, dout_ready;
    logic [1:0] NS;
    logic [7:0] key_init;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] m_key [16];
    logic       m_valid;
    logic [7:0] m_dout;
    bit         aborted;

    rc4_ctrl dut (
        .clk(clk), .rst(rst),
        .key_wr(key_wr), .key_addr(key_addr), .key_wdata(key_wdata),
        .key_len(key_len), .start(start), .stop(stop),
        .ks_byte(ks_byte), .ks_valid(ks_valid),
        .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .NS(NS), .key_init(key_init), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic quiet_inputs();
        key_wr = 1'b0; start = 1'b0; stop = 1'b0;
        din_valid = 1'b0; ks_valid = 1'b0; dout_ready = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_ns"}, 32'(NS), 32'd0);
        check({tag, "_dout_valid"}, 32'(dout_valid), 32'd0);
        check({tag, "_din_ready"}, 32'(din_ready), 32'd0);
        check({tag, "_key_init"}, 32'(key_init), 32'd0);
    endtask

    task automatic write_key(input logic [3:0] a, input logic [7:0] d);
        key_wr = 1'b1; key_addr = a; key_wdata = d;
        @(negedge clk);
        key_wr = 1'b0;
        m_key[a] = d;
    endtask

    // Full session preamble: 256 SINIT cycles then 256 KSA cycles.
    task automatic run_session(input int len, input int abort_k, output bit ab);
        int eff;
        eff = (len == 0 || len > 16) ? 16 : len;
        ab = 1'b0;
        start = 1'b1; key_len = 5'(len);
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 512; k++) begin
            check("sess_ns", 32'(NS), (k < 256) ? 32'd0 : 32'd1);
            check("sess_busy", 32'(busy), 32'd1);
            check("sess_key_init", 32'(key_init),
                  (k >= 256) ? 32'(m_key[(k - 256) % eff]) : 32'd0);
            check("sess_din_ready", 32'(din_ready), 32'd0);
            ks_valid = 1'($urandom); din_valid = 1'($urandom);
            ks_byte = 8'($urandom); din = 8'($urandom);
            dout_ready = 1'($urandom); key_len = 5'($urandom);
            key_wr = 1'b0; start = (k == 50);
            if (k == 300 || k == 301) begin
                key_wr = 1'b1; key_addr = 4'($urandom); key_wdata = 8'($urandom);
            end
            if (k == abort_k) begin
                stop = 1'b1;
                @(negedge clk);
                quiet_inputs();
                check_idle("abort");
                ab = 1'b1;
                return;
            end
            @(negedge clk);
        end
        quiet_inputs();
        check("crypt_ns", 32'(NS), 32'd2);
        m_valid = 1'b0;
    endtask

`ifdef RC4_DROP_EN
    task automatic drop_phase();
        int seen = 0;
        int guard = 0;
        while (seen < 256 && guard < 3000) begin
            ks_valid = 1'($urandom); ks_byte = 8'(seen);
            din_valid = 1'b1; din = 8'($urandom); dout_ready = 1'b1;
            #1;
            check("drop_din_ready", 32'(din_ready), 32'd0);
            check("drop_ns", 32'(NS), 32'd2);
            if (ks_valid) seen++;
            guard++;
            @(negedge clk);
        end
        check("drop_count", 32'(seen), 32'd256);
    endtask
`endif

    // One CRYPT cycle: drive, check against scoreboard, advance scoreboard.
    task automatic crypt_cycle(input logic dv, input logic [7:0] d, input logic kv,
                               input logic [7:0] k, input logic dr);
        logic exp_rdy;
        din_valid = dv; din = d; ks_valid = kv; ks_byte = k; dout_ready = dr;
        #1;
        exp_rdy = kv & (~m_valid | dr);
        check("din_ready", 32'(din_ready), 32'(exp_rdy));
        check("dout_valid", 32'(dout_valid), 32'(m_valid));
        if (m_valid) check("dout", 32'(dout), 32'(m_dout));
        if (dv && exp_rdy) begin
            m_dout = d ^ k; m_valid = 1'b1;
        end else if (dr) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic stop_session();
        quiet_inputs();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check_idle("stop");
        m_valid = 1'b0;
    endtask

    task automatic random_crypt(input int n);
        for (int i = 0; i < n; i++)
            crypt_cycle(1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom), 1'($urandom));
    endtask

    task automatic enter_crypt();
`ifdef RC4_DROP_EN
        drop_phase();
        crypt_cycle(1'b1, 8'h5A, 1'b1, 8'hC7, 1'b1);
        check("drop_first_dout", 32'(dout), 32'h9D);
        check("drop_first_valid", 32'(dout_valid), 32'd1);
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lens [3];
        quiet_inputs();
        key_addr = 4'd0; key_wdata = 8'd0; key_len = 5'd0;
        ks_byte = 8'd0; din = 8'd0;
        m_valid = 1'b0; m_dout = 8'd0;
        for (int i = 0; i < 16; i++) m_key[i] = 8'h00;
        rst = 1'b1;
        #2 rst = 1'b0;

        // Reset holds everything at rest whatever the inputs do.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            key_wr = 1'($urandom); key_addr = 4'($urandom); key_wdata = 8'($urandom);
            key_len = 5'($urandom); start = 1'($urandom); stop = 1'($urandom);
            ks_byte = 8'($urandom); ks_valid = 1'($urandom); din = 8'($urandom);
            din_valid = 1'($urandom); dout_ready = 1'($urandom);
            #1;
            check_idle("reset");
            check("reset_dout", 32'(dout), 32'd0);
        end
        @(negedge clk);
        quiet_inputs();
        rst = 1'b1;
        @(negedge clk);

        // Key store comes out of reset cleared.
        run_session(4, -1, aborted);
        random_crypt(20);
        stop_session();

        // Three-byte key 01 02 03.
        write_key(4'd0, 8'h01);
        write_key(4'd1, 8'h02);
        write_key(4'd2, 8'h03);
        run_session(3, -1, aborted);
        enter_crypt();
        m_valid = 1'b0;
        crypt_cycle(1'b0, 8'h00, 1'b1, 8'h00, 1'b1);
        crypt_cycle(1'b1, 8'h3C, 1'b1, 8'hA5, 1'b0);
        check("xor_dout", 32'(dout), 32'h99);
        check("xor_valid", 32'(dout_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            crypt_cycle(1'b1, 8'($urandom), 1'b1, 8'($urandom), 1'b0);
            check("hold_dout", 32'(dout), 32'h99);
            check("hold_din_ready", 32'(din_ready), 32'd0);
        end
        crypt_cycle(1'b0, 8'h00, 1'b1, 8'h00, 1'b1);
        check("drain_valid", 32'(dout_valid), 32'd0);
        check("drain_din_ready", 32'(din_ready), 32'd1);
        random_crypt(200);
        crypt_cycle(1'b1, 8'h11, 1'b1, 8'h22, 1'b0);
        stop_session();

        // start with stop in IDLE stays idle.
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        check_idle("start_stop");
        @(negedge clk);
        check("start_stop_busy2", 32'(busy), 32'd0);

        // Abort at KSA cycle 100.
        run_session(3, 356, aborted);
        check("aborted", 32'(aborted), 32'd1);
        @(negedge clk);

        // Writes made during the previous sessions must not have landed.
        run_session(3, -1, aborted);
        random_crypt(30);
        stop_session();

        for (int i = 0; i < 16; i++) write_key(4'(i), 8'($urandom));
        lens[0] = 0;
        lens[1] = 17 + int'($urandom_range(0, 14));
        lens[2] = 1 + int'($urandom_range(0, 15));
        for (int s = 0; s < 3; s++) begin
            run_session(lens[s], -1, aborted);
            enter_crypt();
            random_crypt(100);
            stop_session();
        end

        // Reset mid-session drops pending output and clears the key store.
        run_session(7, -1, aborted);
        enter_crypt();
        crypt_cycle(1'b1, 8'h77, 1'b1, 8'h0F, 1'b0);
        rst = 1'b0;
        #1;
        check_idle("midrst");
        check("midrst_dout", 32'(dout), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 16; i++) m_key[i] = 8'h00;
        m_valid = 1'b0;
        @(negedge clk);
        run_session(5, -1, aborted);
        random_crypt(10);
        stop_session();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
